// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO registers with multiply/divide latency tracking and hazard stall
module hilo_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [63:0] aluout_i,
  input  logic [31:0] wdata_i,
  input  logic        rd_en_i,
  input  logic        rd_hi_i,
  input  logic        flush_i,
  output logic [31:0] rd_data_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        stall_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        op_req;
  always_comb begin
    op_req    = op_valid_i & (op_i inside {3'd1, 3'd2, 3'd3, 3'd4});
    busy_o    = state == BUSY;
    stall_o   = busy_o & (op_req | rd_en_i);
    rd_data_o = rd_hi_i ? hi_o : lo_o;
  end
  // While BUSY every HI/LO op stalls, so ops only take effect from IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == BUSY) begin
      cnt <= (cnt != 6'd0) ? cnt - 6'd1 : cnt;
      if (cnt == 6'd0) begin
        hi_o  <= pend_hi;
        lo_o  <= pend_lo;
        state <= IDLE;
      end
    end else if (op_valid_i) begin
      if (op_i == 3'd1 || op_i == 3'd2) begin
        pend_hi <= aluout_i[63:32];
        pend_lo <= aluout_i[31:0];
        cnt     <= (op_i == 3'd1) ? 6'(MUL_LAT - 1) : 6'(DIV_LAT - 1);
        state   <= BUSY;
      end
      hi_o <= (op_i == 3'd3) ? wdata_i : hi_o;
      lo_o <= (op_i == 3'd4) ? wdata_i : lo_o;
    end
  end
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: scoreboard bench for hilo_unit with default latencies (MUL 4, DIV 32)
module tb_hilo_unit;
  logic        clk_i = 0;
  logic        rst_i, op_valid_i, rd_en_i, rd_hi_i, flush_i;
  logic [2:0]  op_i;
  logic [63:0] aluout_i;
  logic [31:0] wdata_i, rd_data_o, hi_o, lo_o;
  logic        busy_o, stall_o;
  int          vectors = 0, errs = 0, n;
  logic [63:0] exp_q[$];
  logic [31:0] rd_q[$];

  hilo_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_valid_i(op_valid_i), .op_i(op_i),
    .aluout_i(aluout_i), .wdata_i(wdata_i), .rd_en_i(rd_en_i), .rd_hi_i(rd_hi_i),
    .flush_i(flush_i), .rd_data_o(rd_data_o), .hi_o(hi_o), .lo_o(lo_o),
    .busy_o(busy_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic pop_commit(input string tag);
    if (exp_q.size() == 0) chk({tag, "_empty"}, 1, 0);
    else chk(tag, {hi_o, lo_o}, exp_q.pop_front());
  endtask

  task automatic pop_read(input string tag);
    if (rd_q.size() == 0) chk({tag, "_empty"}, 1, 0);
    else chk(tag, rd_data_o, rd_q.pop_front());
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy_o && k < lim) begin
      step();
      k++;
    end
    if (busy_o) chk("busy_timeout", 1, 0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] alu, input logic [31:0] wd);
    op_valid_i = 1; op_i = op; aluout_i = alu; wdata_i = wd;
  endtask

  task automatic do_reset;
    rst_i = 1;
    step();
    step();
    rst_i = 0;
  endtask

  initial begin
    op_valid_i = 0; op_i = 0; aluout_i = 0; wdata_i = 0;
    rd_en_i = 0; rd_hi_i = 0; flush_i = 0;
    do_reset();
    chk("rst_hilo", {hi_o, lo_o}, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_stall", stall_o, 0);

    // MUL commit four edges after acceptance
    issue(3'd1, 64'hFFFFFFFF_FFFFFFFA, 0);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
    #1 chk("mul_nostall", stall_o, 0);
    step();
    op_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mul_busy%0d", i), busy_o, 1);
      if (i == 3) chk("mul_precommit", {hi_o, lo_o}, 0);
      step();
    end
    chk("mul_done_busy", busy_o, 0);
    pop_commit("mul_commit");

    // MFHI held behind DIV, starting one cycle after acceptance
    issue(3'd2, {32'h1, 32'h3}, 0);
    exp_q.push_back({32'h1, 32'h3});
    step();
    op_valid_i = 0;
    step();
    rd_en_i = 1; rd_hi_i = 1;
    rd_q.push_back(32'h1);
    #1;
    n = 0;
    while (stall_o && n < 100) begin
      step();
      n++;
    end
    chk("div_stall_cycles", n, 31);
    pop_read("div_read");
    pop_commit("div_commit");
    rd_en_i = 0;

    // MTHI then MTLO, visible the cycle after each edge
    issue(3'd3, 0, 32'hDEADBEEF);
    #1 chk("mthi_nostall", stall_o, 0);
    step();
    chk("mthi_hi", hi_o, 32'hDEADBEEF);
    chk("mthi_lo_kept", lo_o, 32'h3);
    issue(3'd4, 0, 32'h12345678);
    step();
    op_valid_i = 0;
    chk("mtlo_lo", lo_o, 32'h12345678);
    chk("mtlo_hi_kept", hi_o, 32'hDEADBEEF);
    rd_hi_i = 0;
    #1 chk("rd_lo", rd_data_o, 32'h12345678);

    // MTLO stalled behind MUL, lands after the commit
    issue(3'd1, {32'h7, 32'h5}, 0);
    exp_q.push_back({32'h7, 32'h5});
    step();
    issue(3'd4, 0, 32'h0000AAAA);
    #1;
    n = 0;
    while (stall_o && n < 100) begin
      step();
      n++;
    end
    chk("mtlo_stall_cycles", n, 4);
    pop_commit("mul2_commit");
    step();
    op_valid_i = 0;
    chk("mtlo_after_mul", lo_o, 32'h0000AAAA);
    chk("mtlo_after_mul_hi", hi_o, 32'h7);

    // flush at the commit edge suppresses the commit
    do_reset();
    issue(3'd1, {32'h1, 32'h2}, 0);
    exp_q.push_back(64'h0);
    step();
    op_valid_i = 0;
    for (int i = 0; i < 3; i++) step();
    chk("flush_pre_busy", busy_o, 1);
    flush_i = 1;
    step();
    flush_i = 0;
    chk("flush_busy", busy_o, 0);
    pop_commit("flush_nocommit");
    step();
    pop_commit_guard: chk("flush_still_kept", {hi_o, lo_o}, 0);

    // flush in IDLE drops the presented op
    flush_i = 1;
    issue(3'd3, 0, 32'h1111);
    step();
    flush_i = 0; op_valid_i = 0;
    chk("flush_idle_drop", hi_o, 0);

    // back-to-back MUL in the cycle after commit
    issue(3'd1, {32'hA, 32'hB}, 0);
    exp_q.push_back({32'hA, 32'hB});
    step();
    op_valid_i = 0;
    wait_idle(100);
    pop_commit("b2b_first");
    issue(3'd1, {32'hC, 32'hD}, 0);
    exp_q.push_back({32'hC, 32'hD});
    #1 chk("b2b_nostall", stall_o, 0);
    step();
    op_valid_i = 0;
    chk("b2b_busy", busy_o, 1);
    wait_idle(100);
    pop_commit("b2b_second");

    // reset in the middle of a DIV
    issue(3'd3, 0, 32'hDEADBEEF);
    step();
    chk("pre_rst_hi", hi_o, 32'hDEADBEEF);
    issue(3'd2, {32'h55, 32'h66}, 0);
    step();
    op_valid_i = 0;
    for (int i = 0; i < 4; i++) step();
    rst_i = 1;
    step();
    rst_i = 0;
    rd_en_i = 1;
    #1;
    chk("midrst_hilo", {hi_o, lo_o}, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_stall", stall_o, 0);
    rd_en_i = 0;
    issue(3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFFFFFF);
    #1 chk("rsvd_nostall", stall_o, 0);
    step();
    op_valid_i = 0;
    chk("rsvd_hilo", {hi_o, lo_o}, 0);
    chk("rsvd_busy", busy_o, 0);
    chk("sb_drained", exp_q.size() + rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Sits directly downstream of the execute-stage ALU. Consumes its 64-bit result for MULT/MULTU/DIV/DIVU and commits it to the architectural HI/LO registers.
- Models multiply/divide latency with a busy counter and stalls the pipeline on HI/LO hazards.
- Also services MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
- MUL_LAT, 4, clock edges from accepting MULT/MULTU to HI/LO commit (legal 1..63).
- DIV_LAT, 32, clock edges from accepting DIV/DIVU to HI/LO commit (legal 1..63).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- op_valid_i  in  1  op_i is valid this cycle.
- op_i  in  3  operation code:
  - 0 NONE
  - 1 MUL (MULT/MULTU)
  - 2 DIV (DIV/DIVU)
  - 3 MTHI
  - 4 MTLO
  - 5..7 reserved
- aluout_i  in  64  ALU result: [63:32] is the HI value, [31:0] is the LO value; sampled for MUL/DIV.
- wdata_i  in  32  rs value for MTHI/MTLO.
- rd_en_i  in  1  MFHI/MFLO read request this cycle.
- rd_hi_i  in  1  1 = read HI, 0 = read LO.
- flush_i  in  1  cancel any in-flight MUL/DIV.
- rd_data_o  out  32  selected HI/LO register value.
- hi_o  out  32  architectural HI.
- lo_o  out  32  architectural LO.
- busy_o  out  1  MUL/DIV in flight.
- stall_o  out  1  request not accepted this cycle; upstream must hold.

Behaviour:
- Reset (rst_i high at an edge):
  - hi_o = 0, lo_o = 0, busy_o = 0, state IDLE, counter 0, pending HI/LO = 0.
  - rst_i overrides flush_i and all ops.
- States: IDLE, BUSY.
- Accept condition: op_valid_i & ~stall_o & ~flush_i & ~rst_i.
- IDLE, accepted MUL/DIV at edge k:
  - pend_hi <= aluout_i[63:32], pend_lo <= aluout_i[31:0].
  - cnt <= LAT-1, where LAT = MUL_LAT or DIV_LAT.
  - Go to BUSY.
- BUSY, at each edge:
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: hi_o <= pend_hi, lo_o <= pend_lo, go to IDLE.
  - Net effect: the commit occurs at edge k+LAT.
  - busy_o is high in the cycles after edges k .. k+LAT-1 and low after edge k+LAT.
  - LAT = 1 commits at edge k+1.
- IDLE, accepted MTHI at edge k: hi_o <= wdata_i; lo_o unchanged.
- IDLE, accepted MTLO at edge k: lo_o <= wdata_i; hi_o unchanged.
- Visibility: MTHI/MTLO values are visible on hi_o/lo_o/rd_data_o from cycle k+1. There is no same-cycle bypass.
- rd_data_o: combinational, = rd_hi_i ? hi_o : lo_o. Driven regardless of rd_en_i.
- stall_o: combinational, = busy_o & ((op_valid_i & op_i in {1,2,3,4}) | rd_en_i).
  - A stalled op is not accepted and has no side effect.
  - rd_data_o during a stalled read reflects old HI/LO and must not be consumed.
  - stall_o drops in the cycle after the commit edge. The held op or read proceeds that cycle and sees the new HI/LO.
- Ignored ops (no state change, no stall):
  - op_i = 0 or 5..7.
  - op_valid_i = 0.
- flush_i high at an edge:
  - In BUSY: abort, go to IDLE, counter 0, hi_o/lo_o unchanged.
  - Flush at the commit edge (cnt == 0) wins: no commit.
  - Any op presented in the same cycle is dropped.
  - In IDLE: only drops the presented op.
- Data handling:
  - No arithmetic is performed on HI/LO; aluout_i is committed bit-exact.
  - Divide-by-zero results are committed as supplied, with no check.
- Back-to-back: a MUL/DIV presented in the cycle right after the commit edge is accepted (state IDLE, stall_o = 0).

Test Plan:
- MUL commit (MUL_LAT=4):
  - Stimulus: after reset, op=1 with aluout_i=64'hFFFFFFFF_FFFFFFFA, accepted at edge k.
  - Response: busy_o=1 for 4 cycles; hi_o=FFFFFFFF and lo_o=FFFFFFFA after edge k+4; busy_o=0 after edge k+4.
- Read stalled behind DIV (DIV_LAT=32):
  - Stimulus: DIV with aluout_i={32'h1, 32'h3}, then rd_en_i=1, rd_hi_i=1 held.
  - Response: stall_o=1 for 31 cycles following the acceptance cycle; the read completes with rd_data_o=00000001 right after the commit edge.
- MTHI/MTLO:
  - Stimulus: MTHI wdata_i=DEADBEEF at edge k, then MTLO wdata_i=12345678 at edge k+1.
  - Response: hi_o=DEADBEEF from cycle k+1; lo_o=12345678 from cycle k+2; no stall.
- MTLO stalled during MUL:
  - Stimulus: MTLO 0000AAAA presented during a MUL committing lo=00000005.
  - Response: stall_o=1 until commit; final lo_o=0000AAAA (MTLO after MUL).
- Flush at commit edge:
  - Stimulus: MUL (MUL_LAT=4) with pending {1,2}, flush_i=1 at edge k+4.
  - Response: hi_o/lo_o keep their prior values 0/0; busy_o=0 afterwards.
- Reset mid-operation:
  - Stimulus: hi_o=DEADBEEF, DIV in flight, rst_i=1 at edge k+5.
  - Response: hi_o=lo_o=0, busy_o=0, stall_o=0 next cycle; reserved op_i=6 presented after reset causes no change.
